uart_program_loader: RTL and testbench

//  Upstream boot stage of the pipelined RISC-V core: receives a program image over UART and

---
 rtl/loader_pkg.sv | 27 ++
 rtl/uart_rx_byte.sv | 89 ++++++++
 rtl/uart_program_loader.sv | 134 +++++++++++++
 tb/tb_uart_program_loader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared constants, state encodings and baud-rate helper for the UART program loader.
package loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    P_SYNC,
    P_LEN_LO,
    P_LEN_HI,
    P_DATA,
    P_CSUM,
    P_DONE,
    P_ERROR
  } proto_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, byte and framing-error pulses.
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_error
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state;
  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= RX_IDLE;
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      rx_prev     <= 1'b1;
      cnt         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      rx_byte     <= '0;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_meta     <= uart_rx;
      rx_sync     <= rx_meta;
      rx_prev     <= rx_sync;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
          if (rx_prev && !rx_sync) state <= RX_START;
        end
        // A start bit that is high again at mid-bit is a glitch, not a frame.
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              rx_byte    <= shreg;
            end else begin
              frame_error <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: receives a framed program image over UART, writes it to instruction memory and
// releases the core from reset only once the image checksum has been verified.
module uart_program_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BAUD        = 115_200,
  parameter int unsigned IMEM_DEPTH  = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        uart_rx,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_resetn,
  output logic        load_done,
  output logic        load_error,
  output logic        frame_error
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int unsigned WIDX_W       = $clog2(IMEM_DEPTH) + 1;

  logic [7:0]        rx_byte;
  logic              byte_valid;
  proto_state_t      state;
  logic [15:0]       len;
  logic [7:0]        csum;
  logic [WIDX_W-1:0] word_index;
  logic [1:0]        byte_cnt;
  logic [31:0]       word_buf;
  logic [15:0]       len_next;
  logic [31:0]       word_next;
  logic              in_frame;
  logic              last_word;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .resetn     (resetn),
    .uart_rx    (uart_rx),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_error(frame_error)
  );

  assign len_next  = {rx_byte, len[7:0]};
  assign word_next = {rx_byte, word_buf[31:8]};
  assign in_frame  = state inside {P_LEN_LO, P_LEN_HI, P_DATA, P_CSUM};
  assign last_word = (16'(word_index) + 16'd1) == len;

  // Protocol FSM, word assembler and running XOR checksum.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= P_SYNC;
      len         <= '0;
      csum        <= '0;
      word_index  <= '0;
      byte_cnt    <= '0;
      word_buf    <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      core_resetn <= 1'b0;
      load_done   <= 1'b0;
      load_error  <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (frame_error && in_frame) begin
        state       <= P_ERROR;
        load_error  <= 1'b1;
        load_done   <= 1'b0;
        core_resetn <= 1'b0;
      end else if (byte_valid) begin
        case (state)
          P_SYNC, P_DONE, P_ERROR: begin
            if (rx_byte == SYNC_BYTE) begin
              state       <= P_LEN_LO;
              csum        <= '0;
              word_index  <= '0;
              byte_cnt    <= '0;
              core_resetn <= 1'b0;
              load_done   <= 1'b0;
              load_error  <= 1'b0;
            end
          end
          P_LEN_LO: begin
            len[7:0] <= rx_byte;
            csum     <= csum ^ rx_byte;
            state    <= P_LEN_HI;
          end
          P_LEN_HI: begin
            len[15:8] <= rx_byte;
            csum      <= csum ^ rx_byte;
            if (len_next > 16'(IMEM_DEPTH)) begin
              state      <= P_ERROR;
              load_error <= 1'b1;
            end else if (len_next == 16'd0) begin
              state <= P_CSUM;
            end else begin
              state <= P_DATA;
            end
          end
          P_DATA: begin
            word_buf <= word_next;
            csum     <= csum ^ rx_byte;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= 32'({word_index, 2'b00});
              imem_wdata <= word_next;
              word_index <= word_index + WIDX_W'(1);
              if (last_word) state <= P_CSUM;
            end
          end
          P_CSUM: begin
            if (rx_byte == csum) begin
              state       <= P_DONE;
              load_done   <= 1'b1;
              core_resetn <= 1'b1;
            end else begin
              state      <= P_ERROR;
              load_error <= 1'b1;
            end
          end
          default: state <= P_SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for uart_program_loader: serial stimulus at the configured baud rate.
module tb_uart_program_loader;

  localparam int unsigned CLK_HZ = 1_600_000;
  localparam int unsigned BAUD_R = 100_000;
  localparam int unsigned BIT    = CLK_HZ / BAUD_R;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        uart_rx = 1'b1;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_resetn;
  logic        load_done;
  logic        load_error;
  logic        frame_error;

  int          tests = 0;
  int          fails = 0;
  int          fe_count = 0;
  logic        fe_prev = 1'b0;
  logic [63:0] exp_q[$];
  logic [31:0] imem[0:255];

  always #5 clk = ~clk;

  uart_program_loader #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD       (BAUD_R),
    .IMEM_DEPTH (256)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .uart_rx    (uart_rx),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_resetn(core_resetn),
    .load_done  (load_done),
    .load_error (load_error),
    .frame_error(frame_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the expected-write queue.
  always @(negedge clk) begin : monitor
    logic [63:0] e;
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected no write",
                 imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", imem_addr, e[63:32]);
        check("write_data", imem_wdata, e[31:0]);
      end
      imem[imem_addr[9:2]] = imem_wdata;
    end
    if (frame_error) begin
      fe_count++;
      check("frame_error_width", 32'(fe_prev), 32'd0);
    end
    fe_prev = frame_error;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (BIT) @(negedge clk);
    uart_rx = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input byte_q_t bytes);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", imem_addr, 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_core_resetn", 32'(core_resetn), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_error", 32'(load_error), 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_status(input string tag, input logic done, input logic err, input logic core);
    check({tag, "_load_done"}, 32'(load_done), 32'(done));
    check({tag, "_load_error"}, 32'(load_error), 32'(err));
    check({tag, "_core_resetn"}, 32'(core_resetn), 32'(core));
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int fe0;
    repeat (3) @(negedge clk);
    do_reset();

    // 1: valid two-word image
    exp_q.push_back({32'h0, 32'h0000_0013});
    exp_q.push_back({32'h4, 32'h00A0_0093});
    send_frame('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00});
    check_status("t1_pre_csum", 1'b0, 1'b0, 1'b0);
    send_byte(8'h22);
    check_status("t1", 1'b1, 1'b0, 1'b1);
    check("t1_writes_left", 32'(exp_q.size()), 32'd0);
    check("t1_imem0", imem[0], 32'h0000_0013);
    check("t1_imem1", imem[1], 32'h00A0_0093);

    // 2: same image restarted from P_DONE with a bad checksum
    send_byte(8'hA5);
    check_status("t2_restart", 1'b0, 1'b0, 1'b0);
    exp_q.push_back({32'h0, 32'h0000_0013});
    exp_q.push_back({32'h4, 32'h00A0_0093});
    send_frame('{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00, 8'h23});
    check_status("t2", 1'b0, 1'b1, 1'b0);
    check("t2_writes_left", 32'(exp_q.size()), 32'd0);

    // 3: empty image, then a new sync byte re-asserts core reset
    do_reset();
    send_frame('{8'hA5, 8'h00, 8'h00, 8'h00});
    check_status("t3", 1'b1, 1'b0, 1'b1);
    send_byte(8'hA5);
    check_status("t3_resync", 1'b0, 1'b0, 1'b0);

    // 4: length 0x0101 exceeds memory depth
    do_reset();
    send_frame('{8'hA5, 8'h01, 8'h01});
    check_status("t4", 1'b0, 1'b1, 1'b0);

    // 5: bad stop bit on the second data byte, then recovery
    do_reset();
    fe0 = fe_count;
    send_frame('{8'hA5, 8'h02, 8'h00, 8'h13});
    send_byte(8'h00, 1'b0);
    check("t5_frame_error_pulses", 32'(fe_count - fe0), 32'd1);
    check_status("t5_err", 1'b0, 1'b1, 1'b0);
    exp_q.push_back({32'h0, 32'h0000_0013});
    exp_q.push_back({32'h4, 32'h00A0_0093});
    send_frame('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00, 8'h22});
    check_status("t5_recover", 1'b1, 1'b0, 1'b1);
    check("t5_writes_left", 32'(exp_q.size()), 32'd0);

    // 6a: short start glitch inside a frame must not produce a byte
    do_reset();
    send_frame('{8'hA5, 8'h01, 8'h00});
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (BIT / 4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    exp_q.push_back({32'h0, 32'h0000_1037});
    send_frame('{8'h37, 8'h10, 8'h00, 8'h00, 8'h26});
    check_status("t6_glitch", 1'b1, 1'b0, 1'b1);
    check("t6_imem0", imem[0], 32'h0000_1037);

    // 6b: reset in the middle of the payload aborts the load
    exp_q.push_back({32'h0, 32'h4433_2211});
    send_frame('{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55});
    do_reset();
    send_frame('{8'h66, 8'h77, 8'h88});
    check_status("t6_abort", 1'b0, 1'b0, 1'b0);
    check("t6_writes_left", 32'(exp_q.size()), 32'd0);
    check("t6_imem0_kept", imem[0], 32'h4433_2211);

    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
